// File: rtl/sseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Provides the display-word record and the active-low hex segment table.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank_lz;
    } disp_word_t;

    // Index n holds the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/sseg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Ports: nib (4-bit hex digit in), seg (7-bit {g,f,e,d,c,b,a}, active-low out).
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed four-digit seven-segment driver with a one-deep word buffer.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_value/in_dp/
//        in_blank_lz (word handshake); an, seg, dp (active-low drive); frame.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_dp,
    input  logic        in_blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          frame_q, frame_d;
    disp_word_t    disp_q, disp_d;
    disp_word_t    pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          boundary;
    logic          accept;
    logic [3:0]    nib;
    logic [6:0]    dec_seg;
    logic [3:0]    lz;
    logic          blank;

    assign tick     = (cnt_q == CW'(DIV - 1));
    assign boundary = tick && (idx_q == 2'd3);
    assign in_ready = ~pend_full_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        frame_d     = boundary;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        // Only a frame boundary may change what is shown.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        // accept needs an empty pending slot, so it never collides
        // with the transfer above.
        if (accept) begin
            pend_d      = '{value: in_value, dp: in_dp, blank_lz: in_blank_lz};
            pend_full_d = 1'b1;
        end
    end

    // Outputs are computed from the next index/display so the
    // registered pattern lines up with the slot that just started.
    assign nib = disp_d.value[{idx_d, 2'b00} +: 4];

    sseg_decode u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        lz[3] = disp_d.blank_lz && (disp_d.value[15:12] == 4'h0);
        lz[2] = lz[3] && (disp_d.value[11:8] == 4'h0);
        lz[1] = lz[2] && (disp_d.value[7:4] == 4'h0);
        lz[0] = 1'b0;
        blank = lz[idx_d];
        an_d  = blank ? 4'hF : ~(4'b0001 << idx_d);
        seg_d = blank ? SEG_BLANK : dec_seg;
        dp_d  = blank | ~disp_d.dp[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            frame_q     <= 1'b0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            an_q        <= 4'hF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Self-checking bench for sseg_scan with DIV=4 (16-cycle frames).
// Table-driven display vectors plus directed handshake/reset sequences.
module tb_sseg_scan;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [3:0]  in_dp;
    logic        in_blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int n_pass;
    int n_total;

    sseg_scan #(.DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_dp       (in_dp),
        .in_blank_lz (in_blank_lz),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame       (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpi;
        logic            blz;
        logic [3:0][3:0] an_e;
        logic [3:0][6:0] seg_e;
        logic [3:0]      dp_e;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame !== 1'b1 && n < 64);
        if (frame !== 1'b1) chk("frame_timeout", 0, 1);
    endtask

    task automatic check_digit0(input string name, input logic [6:0] s);
        chk({name, "_an"}, {28'd0, an}, 32'hE);
        chk({name, "_seg"}, {25'd0, seg}, {25'd0, s});
    endtask

    initial begin
        int lowcnt;
        int per;
        vecs[0] = '{16'h1234, 4'h0, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'h0050, 4'h0, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE},
                    {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        vecs[2] = '{16'h0000, 4'h0, 1'b1, {4'hF, 4'hF, 4'hF, 4'hE},
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        vecs[3] = '{16'h89EF, 4'h4, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b1011};
        vecs[4] = '{16'h0567, 4'h8, 1'b1, {4'hF, 4'hB, 4'hD, 4'hE},
                    {7'h7F, 7'h12, 7'h02, 7'h78}, 4'hF};
        vecs[5] = '{16'h0C0B, 4'h1, 1'b1, {4'hF, 4'hB, 4'hD, 4'hE},
                    {7'h7F, 7'h46, 7'h40, 7'h03}, 4'b1110};
        vecs[6] = '{16'hA0D0, 4'h0, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE},
                    {7'h08, 7'h40, 7'h21, 7'h40}, 4'hF};
        vecs[7] = '{16'h0050, 4'h4, 1'b1, {4'hF, 4'hF, 4'hD, 4'hE},
                    {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_value = 16'h0;
        in_dp = 4'h0;
        in_blank_lz = 1'b0;

        // Reset state
        #7;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'h1);
        chk("rst_frame", {31'd0, frame}, 32'h0);
        chk("rst_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame period and pulse width
        wait_frame();
        @(negedge clk);
        chk("frame_width", {31'd0, frame}, 32'h0);
        per = 1;
        while (frame !== 1'b1 && per < 64) begin
            @(negedge clk);
            per++;
        end
        chk("frame_period", per, 16);

        // Table-driven display patterns
        for (int v = 0; v < 8; v++) begin
            wait_frame();
            in_valid = 1'b1;
            in_value = vecs[v].val;
            in_dp = vecs[v].dpi;
            in_blank_lz = vecs[v].blz;
            @(negedge clk);
            in_valid = 1'b0;
            wait_frame();
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("v%0d_d%0d_an", v, k), {28'd0, an},
                    {28'd0, vecs[v].an_e[k]});
                chk($sformatf("v%0d_d%0d_seg", v, k), {25'd0, seg},
                    {25'd0, vecs[v].seg_e[k]});
                chk($sformatf("v%0d_d%0d_dp", v, k), {31'd0, dp},
                    {31'd0, vecs[v].dp_e[k]});
                repeat (4) @(negedge clk);
            end
        end

        // Backpressure: 0x1111 then 0x2222 held on in_valid
        wait_frame();
        in_valid = 1'b1;
        in_value = 16'h1111;
        in_dp = 4'h0;
        in_blank_lz = 1'b0;
        @(negedge clk);
        chk("bp_ready_low", {31'd0, in_ready}, 32'h0);
        in_value = 16'h2222;
        lowcnt = 0;
        while (!in_ready && lowcnt < 40) begin
            @(negedge clk);
            lowcnt++;
        end
        chk("bp_low_cycles", lowcnt, 15);
        chk("bp_at_boundary", {31'd0, frame}, 32'h1);
        check_digit0("bp_first", 7'h79);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_held", {31'd0, in_ready}, 32'h0);
        wait_frame();
        check_digit0("bp_second", 7'h24);
        wait_frame();
        check_digit0("bp_no_dup", 7'h24);
        chk("bp_ready_back", {31'd0, in_ready}, 32'h1);

        // Accept on the boundary edge: shown one frame later
        repeat (15) @(negedge clk);
        in_valid = 1'b1;
        in_value = 16'h0009;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bnd_frame", {31'd0, frame}, 32'h1);
        check_digit0("bnd_old", 7'h24);
        chk("bnd_pending", {31'd0, in_ready}, 32'h0);
        wait_frame();
        check_digit0("bnd_new", 7'h10);

        // Reset during digit2 slot with a word pending
        wait_frame();
        repeat (9) @(negedge clk);
        chk("mid_an_d2", {28'd0, an}, 32'hB);
        in_valid = 1'b1;
        in_value = 16'h7777;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_pending", {31'd0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst_dp", {31'd0, dp}, 32'h1);
        chk("mid_rst_frame", {31'd0, frame}, 32'h0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_value = 16'h3333;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, in_ready}, 32'h1);
        check_digit0("rel_d0", 7'h40);
        @(negedge clk);
        @(negedge clk);
        check_digit0("rel_d0_last", 7'h40);
        @(negedge clk);
        chk("rel_first_tick_an", {28'd0, an}, 32'hD);
        wait_frame();
        check_digit0("rel_discarded", 7'h40);
        chk("rel_ready_end", {31'd0, in_ready}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
